// File: rtl/id_hazard_fwd_unit_if.sv
// ID-stage hazard/forwarding bundle: the decoded ID instruction fields in,
// and the forwarding selects plus pipeline hold/bubble/flush controls out.
interface id_hazard_fwd_unit_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wreg;
  logic       id_m2reg;
  logic [4:0] id_rn;
  logic       id_btaken;
  logic [1:0] id_adepen;
  logic [1:0] id_bdepen;
  logic       stall;
  logic       bubble;
  logic       flush_ifid;

  // Decode side: presents the ID instruction, consumes the controls.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_btaken,
    input  id_adepen, id_bdepen, stall, bubble, flush_ifid
  );

  // Hazard unit side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_btaken,
    output id_adepen, id_bdepen, stall, bubble, flush_ifid
  );
endinterface

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage forwarding select, load-use stall and branch flush generator.
// Keeps its own shadow of the EXE and MEM destination fields so no feedback
// from later pipeline stages is needed. LU_STALL sets how many bubbles a
// load-use hazard costs (1..3).
module id_hazard_fwd_unit #(
  parameter int LU_STALL = 1
) (
  input logic                 clk,
  input logic                 clrn,
  id_hazard_fwd_unit_if.slave bus
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LU_STALL - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  logic       exe_wreg;
  logic       exe_m2reg;
  logic [4:0] exe_rn;
  logic       mem_wreg;
  logic       mem_m2reg;
  logic [4:0] mem_rn;

  logic       load_use;
  logic       stall_i;
  logic       bubble_i;
  logic [1:0] adepen_i;
  logic [1:0] bdepen_i;

  // Shadow pipeline: MEM takes EXE, EXE takes the ID destination or a bubble.
  // It keeps moving during a stall because only PC and IF/ID are held.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      exe_wreg  <= 1'b0;
      exe_m2reg <= 1'b0;
      exe_rn    <= 5'd0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_rn    <= 5'd0;
    end else begin
      mem_wreg  <= exe_wreg;
      mem_m2reg <= exe_m2reg;
      mem_rn    <= exe_rn;
      if (bubble_i) begin
        exe_wreg  <= 1'b0;
        exe_m2reg <= 1'b0;
        exe_rn    <= 5'd0;
      end else begin
        exe_wreg  <= bus.id_wreg;
        exe_m2reg <= bus.id_m2reg;
        exe_rn    <= bus.id_rn;
      end
    end
  end

  // Operand A select: r0 never forwards, a non-load in EXE beats MEM,
  // MEM supplies either its ALU result or its load data.
  always_comb begin
    adepen_i = 2'b00;
    if (bus.id_use_rs && (bus.id_rs != 5'd0)) begin
      if (exe_wreg && !exe_m2reg && (exe_rn == bus.id_rs)) begin
        adepen_i = 2'b01;
      end else if (mem_wreg && (mem_rn == bus.id_rs)) begin
        adepen_i = mem_m2reg ? 2'b11 : 2'b10;
      end
    end
  end

  // Operand B select, same priority as operand A.
  always_comb begin
    bdepen_i = 2'b00;
    if (bus.id_use_rt && (bus.id_rt != 5'd0)) begin
      if (exe_wreg && !exe_m2reg && (exe_rn == bus.id_rt)) begin
        bdepen_i = 2'b01;
      end else if (mem_wreg && (mem_rn == bus.id_rt)) begin
        bdepen_i = mem_m2reg ? 2'b11 : 2'b10;
      end
    end
  end

  // A load in EXE whose destination the ID instruction reads cannot be forwarded yet.
  always_comb begin
    load_use = 1'b0;
    if (exe_wreg && exe_m2reg && (exe_rn != 5'd0)) begin
      load_use = (bus.id_use_rs && (bus.id_rs == exe_rn)) ||
                 (bus.id_use_rt && (bus.id_rt == exe_rn));
    end
  end

  // Stall FSM state and bubble counter registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stall FSM: a detected hazard costs LU_STALL cycles of stall+bubble;
  // while stalling no new hazard is evaluated.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_i   = 1'b0;
    bubble_i  = 1'b0;
    case (state)
      RUN: begin
        if (load_use) begin
          stall_i   = 1'b1;
          bubble_i  = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (LU_STALL > 1) ? STALL : RUN;
        end
      end
      STALL: begin
        stall_i  = 1'b1;
        bubble_i = 1'b1;
        if (cnt <= 2'd1) begin
          cnt_nxt   = 2'd0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: begin
        cnt_nxt   = 2'd0;
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.id_adepen  = adepen_i;
  assign bus.id_bdepen  = bdepen_i;
  assign bus.stall      = stall_i;
  assign bus.bubble     = bubble_i;
  // A held branch recurs after the stall releases, so stall simply masks it.
  assign bus.flush_ifid = bus.id_btaken & ~stall_i;

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Directed bench for id_hazard_fwd_unit: one instance with LU_STALL=1 and one
// with LU_STALL=3 fed the same ID instruction stream, each checked against
// hand-computed control vectors {adepen, bdepen, stall, bubble, flush_ifid}.
module tb_id_hazard_fwd_unit;

  logic clk = 1'b0;
  logic clrn;
  int   checks   = 0;
  int   failures = 0;

  id_hazard_fwd_unit_if bus1 ();
  id_hazard_fwd_unit_if bus3 ();

  id_hazard_fwd_unit #(.LU_STALL(1)) dut1 (.clk(clk), .clrn(clrn), .bus(bus1));
  id_hazard_fwd_unit #(.LU_STALL(3)) dut3 (.clk(clk), .clrn(clrn), .bus(bus3));

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  wire [6:0] out1 = {bus1.id_adepen, bus1.id_bdepen, bus1.stall, bus1.bubble, bus1.flush_ifid};
  wire [6:0] out3 = {bus3.id_adepen, bus3.id_bdepen, bus3.stall, bus3.bubble, bus3.flush_ifid};

  function automatic logic [6:0] pk(input logic [1:0] a, input logic [1:0] b,
                                    input logic s, input logic bu, input logic f);
    return {a, b, s, bu, f};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got a=%b b=%b s=%b bu=%b f=%b, expected a=%b b=%b s=%b bu=%b f=%b",
               tag, got[6:5], got[4:3], got[2], got[1], got[0],
               exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [6:0] e1, input logic [6:0] e3);
    checkOutput({tag, ".lu1"}, out1, e1);
    checkOutput({tag, ".lu3"}, out3, e3);
  endtask

  // Present one ID instruction to both units shortly after the falling edge.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic ur, input logic ut,
                               input logic wr, input logic m2,
                               input logic [4:0] rn, input logic bt);
    @(negedge clk);
    bus1.id_rs = rs; bus1.id_rt = rt; bus1.id_use_rs = ur; bus1.id_use_rt = ut;
    bus1.id_wreg = wr; bus1.id_m2reg = m2; bus1.id_rn = rn; bus1.id_btaken = bt;
    bus3.id_rs = rs; bus3.id_rt = rt; bus3.id_use_rs = ur; bus3.id_use_rt = ut;
    bus3.id_wreg = wr; bus3.id_m2reg = m2; bus3.id_rn = rn; bus3.id_btaken = bt;
    #1;
  endtask

  localparam logic [6:0] IDLE  = 7'b0;
  localparam logic [6:0] STALLB = 7'b0000110;

  initial begin
    clrn = 1'b0;
    bus1.id_rs = '0; bus1.id_rt = '0; bus1.id_use_rs = 0; bus1.id_use_rt = 0;
    bus1.id_wreg = 0; bus1.id_m2reg = 0; bus1.id_rn = '0; bus1.id_btaken = 0;
    bus3.id_rs = '0; bus3.id_rt = '0; bus3.id_use_rs = 0; bus3.id_use_rt = 0;
    bus3.id_wreg = 0; bus3.id_m2reg = 0; bus3.id_rn = '0; bus3.id_btaken = 0;
    #3;
    checkBoth("reset", IDLE, IDLE);
    @(negedge clk);
    clrn = 1'b1;

    // Forwarding from EXE and MEM.
    applyStimulus(5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);  checkBoth("add_r3", IDLE, IDLE);
    applyStimulus(5'd3, 5'd3, 1, 1, 1, 0, 5'd4, 0);  checkBoth("exe_fwd", pk(2'b01, 2'b01, 0, 0, 0), pk(2'b01, 2'b01, 0, 0, 0));
    applyStimulus(5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);  checkBoth("add_r3b", IDLE, IDLE);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);  checkBoth("nop", IDLE, IDLE);
    applyStimulus(5'd3, 5'd1, 1, 1, 1, 0, 5'd5, 0);  checkBoth("mem_fwd", pk(2'b10, 2'b00, 0, 0, 0), pk(2'b10, 2'b00, 0, 0, 0));

    // EXE ALU result beats an older load to the same register in MEM.
    applyStimulus(5'd1, 5'd0, 1, 0, 1, 1, 5'd3, 0);  checkBoth("lw_r3", IDLE, IDLE);
    applyStimulus(5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);  checkBoth("add_r3c", IDLE, IDLE);
    applyStimulus(5'd3, 5'd3, 1, 1, 1, 0, 5'd8, 0);  checkBoth("exe_prio", pk(2'b01, 2'b01, 0, 0, 0), pk(2'b01, 2'b01, 0, 0, 0));

    // r0 is never forwarded, and a load to r0 never stalls.
    applyStimulus(5'd1, 5'd1, 1, 1, 1, 0, 5'd0, 0);  checkBoth("add_r0", IDLE, IDLE);
    applyStimulus(5'd0, 5'd0, 1, 1, 1, 0, 5'd7, 0);  checkBoth("r0_exe", IDLE, IDLE);
    applyStimulus(5'd0, 5'd0, 1, 1, 1, 0, 5'd9, 0);  checkBoth("r0_mem", IDLE, IDLE);
    applyStimulus(5'd1, 5'd0, 1, 0, 1, 1, 5'd0, 0);  checkBoth("lw_r0", IDLE, IDLE);
    applyStimulus(5'd0, 5'd0, 1, 1, 1, 0, 5'd10, 0); checkBoth("lw_r0_use", IDLE, IDLE);

    // An unused source field never selects a forward.
    applyStimulus(5'd10, 5'd10, 0, 0, 1, 0, 5'd11, 0); checkBoth("unused", IDLE, IDLE);

    // Load-use on rs: 1 bubble vs 3 bubbles.
    applyStimulus(5'd1, 5'd0, 1, 0, 1, 1, 5'd2, 0);  checkBoth("lw_r2", IDLE, IDLE);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("lu_c0", STALLB, STALLB);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("lu_c1", pk(2'b11, 2'b00, 0, 0, 0), pk(2'b11, 2'b00, 1, 1, 0));
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("lu_c2", IDLE, STALLB);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("lu_c3", IDLE, IDLE);

    // Load-use on rt with a taken branch: stall masks the flush until release.
    applyStimulus(5'd1, 5'd0, 1, 0, 1, 1, 5'd2, 0);  checkBoth("lw_r2b", IDLE, IDLE);
    applyStimulus(5'd0, 5'd2, 1, 1, 0, 0, 5'd0, 1);  checkBoth("br_c0", STALLB, STALLB);
    applyStimulus(5'd0, 5'd2, 1, 1, 0, 0, 5'd0, 1);  checkBoth("br_c1", pk(2'b00, 2'b11, 0, 0, 1), pk(2'b00, 2'b11, 1, 1, 0));
    applyStimulus(5'd0, 5'd2, 1, 1, 0, 0, 5'd0, 1);  checkBoth("br_c2", pk(2'b00, 2'b00, 0, 0, 1), STALLB);
    applyStimulus(5'd0, 5'd2, 1, 1, 0, 0, 5'd0, 1);  checkBoth("br_c3", pk(2'b00, 2'b00, 0, 0, 1), pk(2'b00, 2'b00, 0, 0, 1));

    // Asynchronous reset in the middle of a 3-cycle stall.
    applyStimulus(5'd1, 5'd0, 1, 0, 1, 1, 5'd2, 0);  checkBoth("lw_r2c", IDLE, IDLE);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("rst_c0", STALLB, STALLB);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("rst_c1", pk(2'b11, 2'b00, 0, 0, 0), pk(2'b11, 2'b00, 1, 1, 0));
    #2;
    clrn = 1'b0;
    #1;
    checkBoth("rst_async", IDLE, IDLE);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    checkBoth("rst_release", IDLE, IDLE);
    applyStimulus(5'd2, 5'd0, 1, 1, 1, 0, 5'd6, 0);  checkBoth("rst_run", IDLE, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
